// File: rtl/ssled_capture.sv
// Receive side of the four-digit seven-segment scan bus: samples seg/an,
// rebuilds and glitch-filters whole frames, and reports the score.
module ssled_capture #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_disp,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] score_bcd,
    output logic [13:0] score_bin,
    output logic        score_valid,
    output logic        score_changed,
    output logic        stale,
    output logic        seg_err,
    output logic        an_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] T_PRE = CW'(TIMEOUT - 1);

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [3:0]    sel;
    logic          an_idle;
    logic          an_one;
    logic          an_multi;
    logic [3:0]    dig;
    logic          dig_ok;
    logic          cap_ok;
    logic          cap_bad;
    logic [3:0]    mask;
    logic [3:0]    mask_nx;
    logic          frame_done;
    logic [15:0]   cand;
    logic [15:0]   full_frame;
    logic [15:0]   last_frame;
    logic          last_ok;
    logic          cm_valid;
    logic          c1_valid;
    logic [15:0]   c1_frame;
    logic [13:0]   p_hi;
    logic [6:0]    p_lo;
    logic [13:0]   p_hi_nx;
    logic [6:0]    p_lo_nx;
    logic [CW-1:0] cnt;

    // S0: plain input registers
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            seg_q <= 7'h7f;
            an_q  <= 4'hf;
        end else begin
            seg_q <= seg;
            an_q  <= an;
        end
    end

    always_comb begin
        dig_ok = 1'b1;
        dig    = 4'd0;
        case (seg_q)
            7'b1000000: dig = 4'd0;
            7'b1111001: dig = 4'd1;
            7'b0100100: dig = 4'd2;
            7'b0110000: dig = 4'd3;
            7'b0011001: dig = 4'd4;
            7'b0010010: dig = 4'd5;
            7'b0000010: dig = 4'd6;
            7'b1111000: dig = 4'd7;
            7'b0000000: dig = 4'd8;
            7'b0010000: dig = 4'd9;
            default:    dig_ok = 1'b0;
        endcase
    end

    // sel is one-hot exactly when a single anode is low
    assign sel      = ~an_q;
    assign an_idle  = (sel == 4'd0);
    assign an_one   = !an_idle && ((sel & (sel - 4'd1)) == 4'd0);
    assign an_multi = !an_idle && !an_one;
    assign cap_ok   = an_one && dig_ok;
    assign cap_bad  = an_one && !dig_ok;

    assign mask_nx    = mask | sel;
    assign frame_done = cap_ok && (mask_nx == 4'hf);

    always_comb begin
        full_frame = cand;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) full_frame[4*i +: 4] = dig;
        end
    end

    // S1: slot capture, frame assembly and two-frame glitch filter
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            mask       <= 4'd0;
            cand       <= 16'd0;
            last_frame <= 16'd0;
            last_ok    <= 1'b0;
            cm_valid   <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
        end else begin
            seg_err  <= cap_bad;
            an_err   <= an_multi;
            cm_valid <= 1'b0;
            if (an_multi || cap_bad) begin
                mask    <= 4'd0;
                last_ok <= 1'b0;
            end else if (cap_ok) begin
                cand <= full_frame;
                if (frame_done) begin
                    mask       <= 4'd0;
                    last_frame <= full_frame;
                    last_ok    <= 1'b1;
                    cm_valid   <= last_ok && (last_frame == full_frame);
                end else begin
                    mask <= mask_nx;
                end
            end
        end
    end

    assign p_hi_nx = {10'd0, last_frame[15:12]} * 14'd1000
                   + {10'd0, last_frame[11:8]} * 14'd100;
    assign p_lo_nx = {3'd0, last_frame[7:4]} * 7'd10
                   + {3'd0, last_frame[3:0]};

    // C1: last_frame still holds the committed frame on this edge
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            c1_valid <= 1'b0;
            c1_frame <= 16'd0;
            p_hi     <= 14'd0;
            p_lo     <= 7'd0;
        end else begin
            c1_valid <= cm_valid;
            if (cm_valid) begin
                c1_frame <= last_frame;
                p_hi     <= p_hi_nx;
                p_lo     <= p_lo_nx;
            end
        end
    end

    // C2: publish
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            score_bcd     <= 16'd0;
            score_bin     <= 14'd0;
            score_valid   <= 1'b0;
            score_changed <= 1'b0;
        end else begin
            score_valid   <= c1_valid;
            score_changed <= c1_valid && (c1_frame != score_bcd);
            if (c1_valid) begin
                score_bcd <= c1_frame;
                score_bin <= p_hi + {7'd0, p_lo};
            end
        end
    end

    // stale is sticky from reset until the first commit
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            stale <= 1'b1;
        end else if (c1_valid) begin
            cnt   <= '0;
            stale <= 1'b0;
        end else begin
            if (cnt != T_MAX) cnt <= cnt + 1'b1;
            if (cnt == T_PRE) stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssled_capture.sv
// Bench for ssled_capture: random scan traffic against a frame-level
// reference model plus a few literal spot checks.
module tb_ssled_capture;

    localparam int TO = 64;
    localparam int NE = 20000;

    logic        clk_disp = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7f;
    logic [3:0]  an = 4'hf;
    logic [15:0] score_bcd;
    logic [13:0] score_bin;
    logic        score_valid;
    logic        score_changed;
    logic        stale;
    logic        seg_err;
    logic        an_err;

    ssled_capture #(.TIMEOUT(TO)) dut (
        .clk_disp(clk_disp),
        .rst(rst),
        .seg(seg),
        .an(an),
        .score_bcd(score_bcd),
        .score_bin(score_bin),
        .score_valid(score_valid),
        .score_changed(score_changed),
        .stale(stale),
        .seg_err(seg_err),
        .an_err(an_err)
    );

    always #5 clk_disp = ~clk_disp;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    bit ev_commit[NE];
    int ev_val[NE];
    bit ev_seg[NE];
    bit ev_an[NE];

    logic [6:0] pat[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

    int md[4];
    bit mh[4];
    int prev_val;
    bit prev_ok;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %0h want %0h", nm, edge_n, act, exp);
        end
    endtask

    function automatic int decode(logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return 16'(((v / 1000) << 12) | (((v / 100) % 10) << 8)
                 | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) mh[i] = 0;
    endfunction

    // p is the edge at which the pins are first sampled
    function automatic void model_step(logic [6:0] s, logic [3:0] a, int p);
        int zeros = 0;
        int k = 0;
        int d;
        int v;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; k = i; end
        if (zeros == 0) return;
        if (zeros > 1) begin
            ev_an[p + 1] = 1;
            model_clear();
            prev_ok = 0;
            return;
        end
        d = decode(s);
        if (d < 0) begin
            ev_seg[p + 1] = 1;
            model_clear();
            prev_ok = 0;
            return;
        end
        md[k] = d;
        mh[k] = 1;
        if (mh[0] && mh[1] && mh[2] && mh[3]) begin
            v = md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
            model_clear();
            if (prev_ok && prev_val == v) begin
                ev_commit[p + 3] = 1;
                ev_val[p + 3] = v;
            end
            prev_val = v;
            prev_ok = 1;
        end
    endfunction

    task automatic drive(logic [6:0] s, logic [3:0] a);
        @(negedge clk_disp);
        seg = s;
        an = a;
        if (!rst) model_step(s, a, edge_n + 1);
    endtask

    task automatic idle(int n);
        repeat (n) drive(7'h7f, 4'hf);
    endtask

    task automatic frame(int d3, int d2, int d1, int d0);
        drive(pat[d3], 4'b0111);
        drive(pat[d2], 4'b1011);
        drive(pat[d1], 4'b1101);
        drive(pat[d0], 4'b1110);
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk_disp);
        rst = 1'b1;
        seg = 7'h7f;
        an = 4'hf;
        #1;
        chk("rst_bcd", score_bcd, 0);
        chk("rst_bin", score_bin, 0);
        chk("rst_valid", score_valid, 0);
        chk("rst_changed", score_changed, 0);
        chk("rst_seg_err", seg_err, 0);
        chk("rst_an_err", an_err, 0);
        chk("rst_stale", stale, 1);
        model_clear();
        prev_ok = 0;
        for (int e = edge_n + 1; e < edge_n + 8 && e < NE; e++) begin
            ev_commit[e] = 0;
            ev_seg[e] = 0;
            ev_an[e] = 0;
        end
        repeat (cycles) @(negedge clk_disp);
        rst = 1'b0;
    endtask

    // checks published score right after the C2 edge following 3 idles
    task automatic lit_score(string nm, int v, logic chg);
        idle(3);
        @(posedge clk_disp);
        #2;
        chk({nm, "_valid"}, score_valid, 1);
        chk({nm, "_bcd"}, score_bcd, to_bcd(v));
        chk({nm, "_bin"}, score_bin, v);
        chk({nm, "_changed"}, score_changed, chg);
    endtask

    initial begin
        int exp_val = 0;
        bit committed = 0;
        int last_c = 0;
        logic exp_chg;
        forever begin
            @(posedge clk_disp);
            edge_n++;
            #1;
            if (rst) begin
                exp_val = 0;
                committed = 0;
                continue;
            end
            exp_chg = 0;
            if (ev_commit[edge_n]) begin
                exp_chg = (ev_val[edge_n] != exp_val);
                exp_val = ev_val[edge_n];
                committed = 1;
                last_c = edge_n;
            end
            chk("score_valid", score_valid, ev_commit[edge_n]);
            chk("score_changed", score_changed, exp_chg);
            chk("score_bcd", score_bcd, to_bcd(exp_val));
            chk("score_bin", score_bin, exp_val);
            chk("seg_err", seg_err, ev_seg[edge_n]);
            chk("an_err", an_err, ev_an[edge_n]);
            chk("stale", stale, !committed || (edge_n - last_c >= TO));
        end
    end

    initial begin
        int v;
        int reps;
        int d[4];
        int r;
        logic [6:0] s;
        logic [3:0] a;
        prev_ok = 0;
        model_clear();
        do_reset(3);

        frame(1, 2, 3, 4);
        frame(1, 2, 3, 4);
        lit_score("first", 1234, 1'b1);
        repeat (3) frame(1, 2, 3, 4);

        frame(9, 9, 9, 9);
        frame(9, 9, 9, 9);
        lit_score("nines", 9999, 1'b1);

        drive(pat[9], 4'b0111);
        drive(pat[9], 4'b1011);
        drive(7'b0111111, 4'b1101);
        drive(pat[9], 4'b1110);
        repeat (3) frame(9, 9, 9, 9);

        frame(5, 6, 7, 8);
        drive(pat[5], 4'b1100);
        repeat (3) frame(5, 6, 7, 8);

        frame(5, 6, 7, 8);
        idle(70);
        chk("stale_hold", stale, 1);
        frame(0, 0, 4, 2);
        frame(0, 0, 4, 2);

        frame(3, 1, 4, 1);
        drive(pat[3], 4'b0111);
        drive(pat[1], 4'b1011);
        do_reset(2);
        repeat (3) frame(3, 1, 4, 1);

        for (int it = 0; it < 300; it++) begin
            v = $urandom_range(0, 9999);
            d[3] = v / 1000;
            d[2] = (v / 100) % 10;
            d[1] = (v / 10) % 10;
            d[0] = v % 10;
            reps = $urandom_range(1, 3);
            if ($urandom_range(0, 99) < 2) do_reset($urandom_range(1, 3));
            for (int rp = 0; rp < reps; rp++) begin
                for (int k = 3; k >= 0; k--) begin
                    r = $urandom_range(0, 99);
                    if (r < 8) idle(1);
                    r = $urandom_range(0, 99);
                    if (r < 3) begin
                        do s = 7'($urandom); while (decode(s) >= 0);
                        a = 4'hf;
                        a[k] = 1'b0;
                        drive(s, a);
                    end else if (r < 6) begin
                        do a = 4'($urandom); while ($countones(~a) < 2);
                        drive(7'($urandom), a);
                    end else if (r < 9) begin
                        a = 4'hf;
                        a[k] = 1'b0;
                        drive(pat[$urandom_range(0, 9)], a);
                    end
                    a = 4'hf;
                    a[k] = 1'b0;
                    drive(pat[d[k]], a);
                end
            end
        end
        idle(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssled_capture.md
# ssled_capture

Receive-side companion to the four-digit seven-segment scan driver: samples the multiplexed, active-low `seg`/`an` stream, decodes each lit digit, assembles and glitch-filters complete four-digit frames, and presents the captured score as BCD and as binary. It sits on the board-to-board and self-check path, watching a display bus driven at the `clk_disp` scan rate. It flags malformed anode or segment patterns and reports when the display has stopped producing valid frames.

## Interface
- `TIMEOUT`, default 64: cycles without a commit before `stale` asserts; must be at least 2.
- `clk_disp`  in  1  scan clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `seg`  in  7  segment pattern, active-low, `seg[6]`=CG … `seg[0]`=CA.
- `an`  in  4  anode select, active-low, `an[k]` selects digit k (`an[3]`=most significant).
- `score_bcd`  out  16  last committed frame, digit k in bits [4k+3:4k].
- `score_bin`  out  14  binary value of `score_bcd` (0–9999).
- `score_valid`  out  1  one-cycle pulse on each commit.
- `score_changed`  out  1  one-cycle pulse with `score_valid` when the committed value differs from the previous `score_bcd`.
- `stale`  out  1  level; no commit within the last `TIMEOUT` cycles.
- `seg_err`  out  1  one-cycle pulse; undecodable segment pattern on a selected digit.
- `an_err`  out  1  one-cycle pulse; more than one anode low.

## Operation
- Stage S0: `seg` and `an` are registered every cycle as `seg_q` and `an_q`.
- Decode table for `seg_q` (CG..CA): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other pattern is invalid. 0000000 always decodes as 8.
- Stage S1 (capture), based on `an_q`:
  - 1111: idle slot; no state change.
  - Exactly one zero at index k, valid segment pattern: `cand[k]` takes the digit and `mask[k]` is set. A repeat of an already-set slot overwrites it without error.
  - Exactly one zero, invalid pattern: `seg_err` pulses, `mask` clears, and the frame is discarded.
  - Two or more zeros: `an_err` pulses, `mask` clears, and the segment pattern is ignored.
- Frame complete: the capture that sets the last bit of `mask` counts as part of the frame. On that edge:
  - `mask` clears.
  - `last_frame` takes the full candidate, including the new digit, and `last_ok` is set.
  - If `last_ok` was already set and the old `last_frame` equals the new candidate, a commit is issued.
  - Otherwise nothing is output.
- The glitch filter therefore requires two consecutive identical complete frames for each commit. With a steady input, every complete frame after the first commits.
- Commit pipeline:
  - C1: register the frame and compute the partial sums p_hi = d3·1000 + d2·100 and p_lo = d1·10 + d0.
  - C2: `score_bin` = p_hi + p_lo. `score_bcd`, `score_valid` and `score_changed` update on the same edge.
- Stale counter:
  - Cleared on the C2 edge of each commit; otherwise increments and saturates at `TIMEOUT`.
  - `stale` = 1 when the counter equals `TIMEOUT`, and 0 from the C2 edge of any commit.
- Reset values: `score_bcd`=0, `score_bin`=0, `score_valid`=0, `score_changed`=0, `seg_err`=0, `an_err`=0, `stale`=1. Reset also clears `mask`, `last_ok`, the pipeline and the counter. Reset mid-frame or mid-pipeline drops all in-flight data.

## Timing
- A pattern on the pins at edge E is registered at E+1 (S0) and captured at E+2 (S1).
- Frame complete occurs at the S1 edge of the final slot. The C1 and C2 edges follow at +1 and +2.
- Pin-to-`score_valid` latency is 4 edges from the final slot.
- `seg_err` and `an_err` assert on the S1 edge, 2 edges after the pins.
- The block accepts one new slot per cycle, with no back-pressure, and supports back-to-back frames.
- Simultaneous events:
  - A commit in C2 while a new frame completes in S1: both proceed, because the pipeline is fully registered.
  - The stale counter reaching `TIMEOUT` on the same edge as a C2 commit: the commit wins and `stale` = 0.

## Test plan
- Drive a steady scan of 1,2,3,4 on digits 3..0, one digit per cycle, after reset. The first `score_valid` occurs 4 edges after the final slot of the second frame, with `score_bcd`=0x1234, `score_bin`=1234 and `score_changed`=1. Subsequent pulses every 4 cycles have `score_changed`=0.
- Change the digits to 9,9,9,9 mid-run. Exactly one frame is rejected, then the commit shows 0x9999, `score_bin`=9999 and `score_changed`=1.
- Inject `seg`=0111111 on digit 1. `seg_err` pulses 2 cycles later and the frame is dropped. There is no commit until two clean identical frames follow.
- Drive `an`=1100 for one cycle. `an_err` pulses, `mask` clears, and the following frame does not commit.
- Hold `an`=1111 after a commit. `stale` rises exactly `TIMEOUT`=64 cycles after the commit and clears on the C2 edge of the next commit.
- Assert `rst` during the second frame. All outputs return to their reset values immediately, and two full frames are required before `score_valid`.
